// File: rtl/ov7670_cfg_pkg.sv
// Shared constants, sequencer state encoding and SCCB frame layout for the OV7670 configuration path.
package ov7670_cfg_pkg;

  localparam logic [15:0] CFG_END       = 16'hFFFF;
  localparam logic [15:0] CFG_DELAY     = 16'hFFF0;
  localparam logic [7:0]  SCCB_WRITE_ID = 8'h42;
  localparam int          SCCB_FRAME_BITS = 27;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_WRITE,
    ST_DELAY,
    ST_NEXT,
    ST_DONE
  } cfg_state_t;

  // Don't-care bit after each byte is sent as 1, i.e. the line is released.
  function automatic logic [SCCB_FRAME_BITS-1:0] sccb_frame(input logic [7:0] id,
                                                            input logic [7:0] r,
                                                            input logic [7:0] v);
    return {id, 1'b1, r, 1'b1, v, 1'b1};
  endfunction

endpackage

// File: rtl/ov7670_config_ctrl_sccb.sv
// SCCB 3-phase write master: bit-timing divider, 27-bit shift engine, start/stop generation.
module sccb_write_master
  import ov7670_cfg_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 25_000_000,
  parameter int SCCB_FREQ_HZ = 100_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [7:0] id,
  input  logic [7:0] reg_addr,
  input  logic [7:0] val,
  output logic       ack,
  output logic       sioc,
  output logic       siod_low
);

  localparam int T  = CLK_FREQ_HZ / SCCB_FREQ_HZ;
  localparam int CW = $clog2(T);
  localparam int IW = $clog2(T + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(T - 1);
  localparam logic [CW-1:0] CNT_Q1   = CW'(T / 4);
  localparam logic [CW-1:0] CNT_H    = CW'(T / 2);
  localparam logic [IW-1:0] IDLE_MAX = IW'(T);
  localparam logic [4:0]    SLOT_START = 5'd1;
  localparam logic [4:0]    SLOT_STOP  = 5'd29;

  if (T < 4) begin : g_bad_divider
    $error("sccb_write_master: bit period must be at least 4 clk cycles");
  end

  // slot 0: waiting for bus idle, 1: start, 2..28: frame bits, 29: stop
  logic                       active;
  logic [4:0]                 slot;
  logic [CW-1:0]              cnt;
  logic [IW-1:0]              idle_cnt;
  logic [SCCB_FRAME_BITS-1:0] shift;
  logic                       idle_ok, begin_start, slot_end, sioc_nxt, low_nxt;

  assign idle_ok     = (idle_cnt == IDLE_MAX);
  assign begin_start = idle_ok && (active ? (slot == 5'd0) : req);
  assign slot_end    = active && (slot != 5'd0) && (cnt == CNT_LAST);

  // Outputs are registered from the current slot/count; begin_start drives the
  // first start-slot value directly so the start is not delayed by a cycle.
  always_comb begin
    sioc_nxt = 1'b1;
    low_nxt  = 1'b0;
    if (begin_start) begin
      low_nxt = 1'b1;
    end else if (active && slot == SLOT_START) begin
      sioc_nxt = (cnt < CNT_H);
      low_nxt  = 1'b1;
    end else if (active && slot != 5'd0) begin
      sioc_nxt = (cnt >= CNT_H);
      if (cnt < CNT_Q1)
        low_nxt = siod_low;
      else if (slot == SLOT_STOP)
        low_nxt = 1'b1;
      else
        low_nxt = ~shift[SCCB_FRAME_BITS-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      slot     <= '0;
      cnt      <= '0;
      idle_cnt <= IDLE_MAX;
      shift    <= '0;
      ack      <= 1'b0;
      sioc     <= 1'b1;
      siod_low <= 1'b0;
    end else begin
      sioc     <= sioc_nxt;
      siod_low <= low_nxt;
      ack      <= 1'b0;
      if (!active && req) begin
        active <= 1'b1;
        shift  <= sccb_frame(id, reg_addr, val);
      end
      if (begin_start) begin
        slot <= SLOT_START;
        cnt  <= CW'(1);
      end else if (!active && req) begin
        slot <= '0;
        cnt  <= '0;
      end else if (slot_end) begin
        cnt <= '0;
        if (slot == SLOT_STOP) begin
          active   <= 1'b0;
          ack      <= 1'b1;
          idle_cnt <= '0;
        end else begin
          slot <= slot + 5'd1;
          if (slot != SLOT_START) shift <= shift << 1;
        end
      end else if (active && slot != 5'd0) begin
        cnt <= cnt + CW'(1);
      end
      if (!(active && slot != 5'd0) && !idle_ok) idle_cnt <= idle_cnt + IW'(1);
    end
  end

endmodule

// File: rtl/ov7670_config_ctrl.sv
// OV7670 configuration sequencer: walks the config ROM and issues SCCB writes and delays.
module ov7670_config_ctrl
  import ov7670_cfg_pkg::*;
#(
  parameter int         CLK_FREQ_HZ  = 25_000_000,
  parameter int         SCCB_FREQ_HZ = 100_000,
  parameter int         DELAY_MS     = 10,
  parameter logic [7:0] CAM_ID       = SCCB_WRITE_ID
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_dout,
  output logic        sioc,
  inout  wire         siod,
  output logic        busy,
  output logic        done
);

  localparam longint DELAY_CLKS = longint'(DELAY_MS) * longint'(CLK_FREQ_HZ) / 1000;
  localparam int     DW         = (DELAY_CLKS > 1) ? $clog2(DELAY_CLKS) : 1;
  localparam logic [DW-1:0] DLY_LAST = DW'(DELAY_CLKS - 1);

  if (DELAY_CLKS < 1) begin : g_bad_delay
    $error("ov7670_config_ctrl: delay must be at least one clk cycle");
  end

  cfg_state_t    state, state_nxt;
  logic          fetch_cnt, issued, req, ack, siod_low;
  logic [DW-1:0] dly_cnt;
  logic [15:0]   word_q;

  assign req  = (state == ST_WRITE) && !issued;
  assign siod = siod_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_FETCH;
      ST_FETCH:         if (fetch_cnt) state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (rom_dout == CFG_END)        state_nxt = ST_DONE;
        else if (rom_dout == CFG_DELAY) state_nxt = ST_DELAY;
        else                            state_nxt = ST_WRITE;
      end
      ST_WRITE:         if (ack) state_nxt = ST_NEXT;
      ST_DELAY:         if (dly_cnt == DLY_LAST) state_nxt = ST_NEXT;
      ST_NEXT:          state_nxt = (rom_addr == 8'hFF) ? ST_DONE : ST_FETCH;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr  <= '0;
      fetch_cnt <= 1'b0;
      dly_cnt   <= '0;
      word_q    <= '0;
      issued    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      fetch_cnt <= (state == ST_FETCH) ? ~fetch_cnt : 1'b0;
      dly_cnt   <= (state == ST_DELAY) ? dly_cnt + DW'(1) : '0;
      issued    <= (state == ST_WRITE);
      if (state == ST_DECODE) word_q <= rom_dout;
      if ((state == ST_IDLE || state == ST_DONE) && start)
        rom_addr <= '0;
      else if (state == ST_NEXT && rom_addr != 8'hFF)
        rom_addr <= rom_addr + 8'd1;
      busy <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
      done <= (state_nxt == ST_DONE);
    end
  end

  sccb_write_master #(
    .CLK_FREQ_HZ  (CLK_FREQ_HZ),
    .SCCB_FREQ_HZ (SCCB_FREQ_HZ)
  ) u_sccb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .id       (CAM_ID),
    .reg_addr (word_q[15:8]),
    .val      (word_q[7:0]),
    .ack      (ack),
    .sioc     (sioc),
    .siod_low (siod_low)
  );

endmodule

// File: tb/tb_ov7670_config_ctrl.sv
// Scoreboard bench for ov7670_config_ctrl: ROM model, SCCB bus decoder and expected-write queue.
module tb_ov7670_config_ctrl;
  import ov7670_cfg_pkg::*;

  localparam int T   = 10;
  localparam int DLY = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_dout = 16'h0000;
  logic        sioc, busy, done;
  wire         siod;

  pullup (siod);
  always #5 clk = ~clk;

  logic [15:0] rom [256];
  always @(posedge clk) rom_dout <= rom[rom_addr];

  ov7670_config_ctrl #(
    .CLK_FREQ_HZ  (1_000_000),
    .SCCB_FREQ_HZ (100_000),
    .DELAY_MS     (1),
    .CAM_ID       (8'h42)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout),
    .sioc     (sioc),
    .siod     (siod),
    .busy     (busy),
    .done     (done)
  );

  int total = 0;
  int bad   = 0;
  logic [23:0] exp_q [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_range(input string nm, input longint act, input longint lo, input longint hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // ---------------- bus monitor ----------------
  logic        p_scl = 1'b1, p_sda = 1'b1, s_scl, s_sda, p_done = 1'b0;
  logic        in_xfer = 1'b0;
  int          nbits = 0, edge_viol = 0, bus_edges = 0, sioc_edges = 0, done_rises = 0;
  logic [26:0] sh = '0;
  longint      cyc = 0;
  longint      stop_t [$];
  longint      start_t [$];
  int          stop_se [$];
  int          start_se [$];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      in_xfer = 1'b0;
      p_scl = 1'b1;
      p_sda = 1'b1;
      p_done = 1'b0;
    end else begin
      s_scl = sioc;
      s_sda = siod;
      if (s_scl != p_scl) sioc_edges++;
      if (s_scl != p_scl || s_sda != p_sda) bus_edges++;
      if (done && !p_done) done_rises++;
      p_done = done;
      if (s_sda != p_sda) begin
        if (s_scl != p_scl) edge_viol++;
        else if (s_scl && !s_sda) begin
          if (in_xfer) edge_viol++;
          in_xfer = 1'b1;
          nbits = 0;
          start_t.push_back(cyc);
          start_se.push_back(sioc_edges);
        end else if (s_scl && s_sda) begin
          if (!in_xfer) edge_viol++;
          else begin
            in_xfer = 1'b0;
            stop_t.push_back(cyc);
            stop_se.push_back(sioc_edges);
            check("frame_bits", nbits, 27);
            if (exp_q.size() == 0) check("unexpected_write", {sh[26:19], sh[17:10], sh[8:1]}, 32'hFFFFFFFF);
            else check("write_word", {sh[26:19], sh[17:10], sh[8:1]}, exp_q.pop_front());
          end
        end
      end
      if (s_scl && !p_scl && in_xfer && nbits < 27) begin
        sh = {sh[25:0], s_sda};
        nbits++;
      end
      p_scl = s_scl;
      p_sda = s_sda;
    end
  end

  // ---------------- reference model and stimulus helpers ----------------
  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    do w = 16'($urandom); while (w == 16'hFFFF || w == 16'hFFF0);
    return w;
  endfunction

  function automatic int model_expect();
    for (int a = 0; a < 256; a++) begin
      if (rom[a] == 16'hFFFF) return a;
      if (rom[a] != 16'hFFF0) exp_q.push_back({8'h42, rom[a]});
    end
    return 255;
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_run(input string nm, input int end_addr, input int budget, input int rises0);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_range({nm, "_cycles_to_done"}, n, 0, budget - 1);
    repeat (3) @(negedge clk);
    check({nm, "_done"}, done, 1);
    check({nm, "_busy"}, busy, 0);
    check({nm, "_rom_addr"}, rom_addr, end_addr);
    check({nm, "_pending_writes"}, exp_q.size(), 0);
    check({nm, "_done_rises"}, done_rises - rises0, 1);
    check({nm, "_siod_edge_rule"}, edge_viol, 0);
  endtask

  int ea, r0, n, gap, i0;

  initial begin
    clear_rom();
    repeat (4) @(negedge clk);
    check("rst_sioc", sioc, 1);
    check("rst_siod", siod, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rom_addr", rom_addr, 0);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("idle_after_reset", bus_edges, 0);

    // single write
    clear_rom();
    rom[0] = 16'h1180;
    ea = model_expect();
    r0 = done_rises;
    pulse_start();
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    finish_run("single", ea, 2000, r0);

    // delay between writes
    clear_rom();
    rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1214;
    ea = model_expect();
    r0 = done_rises;
    i0 = stop_t.size();
    pulse_start();
    finish_run("delay", ea, 4000, r0);
    if (stop_t.size() >= i0 + 1 && start_t.size() >= i0 + 2) begin
      gap = int'(start_t[i0 + 1] - stop_t[i0]);
      check_range("delay_gap", gap, DLY - T, DLY + T);
      check("delay_sioc_quiet", start_se[i0 + 1] - stop_se[i0], 0);
    end else check("delay_frames_seen", stop_t.size() - i0, 2);

    // full program: 74 writes with a soft-reset delay near the top
    clear_rom();
    rom[0] = 16'h1280; rom[1] = 16'hFFF0;
    for (int i = 2; i < 75; i++) rom[i] = rand_word();
    ea = model_expect();
    r0 = done_rises;
    pulse_start();
    finish_run("full", ea, 40000, r0);

    // start while busy is ignored; start after done replays from address 0
    clear_rom();
    for (int i = 0; i < 6; i++) rom[i] = rand_word();
    ea = model_expect();
    r0 = done_rises;
    pulse_start();
    repeat ($urandom_range(200, 900)) @(negedge clk);
    pulse_start();
    check("busy_after_ignored_start", busy, 1);
    finish_run("ignored_start", ea, 5000, r0);
    ea = model_expect();
    r0 = done_rises;
    pulse_start();
    check("replay_done_cleared", done, 0);
    check("replay_busy", busy, 1);
    check("replay_rom_addr", rom_addr, 0);
    finish_run("replay", ea, 5000, r0);

    // reset during the register phase of the first write
    clear_rom();
    rom[0] = rand_word(); rom[1] = rand_word();
    void'(model_expect());
    pulse_start();
    n = 0;
    while (!(in_xfer && nbits >= 10 && nbits <= 16) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_range("reached_reg_phase", n, 0, 4999);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_sioc", sioc, 1);
    check("midrst_siod", siod, 1);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_rom_addr", rom_addr, 0);
    check("midrst_fsm", 32'(dut.state), 32'(ST_IDLE));
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    ea = model_expect();
    r0 = done_rises;
    pulse_start();
    finish_run("after_reset", ea, 3000, r0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
